// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the R2SDF FFT stages.
// Twiddle constants are Q2.(TW-2): 1.0 maps to 2^(TW-2).
package fft_pkg;

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } phase_e;

    localparam real PI = 3.14159265358979323846;

    function automatic int q_round(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    function automatic int tw_cos(input int k, input int n, input int tw);
        real ang;
        ang = 2.0 * PI * real'(k) / real'(n);
        return q_round($cos(ang) * real'(1 << (tw - 2)));
    endfunction

    function automatic int tw_sin(input int k, input int n, input int tw);
        real ang;
        ang = 2.0 * PI * real'(k) / real'(n);
        return q_round($sin(ang) * real'(1 << (tw - 2)));
    endfunction

endpackage

// File: rtl/sdf_twiddle_rom.sv
// Registered twiddle ROM: W_N^k (forward) or its conjugate (inv=1).
// One-cycle read latency; index 0 yields exactly (1.0, 0).
module sdf_twiddle_rom
    import fft_pkg::*;
#(
    parameter int N  = 8,
    parameter int TW = 18
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [$clog2(N)-1:0]   k,
    input  logic                   inv,
    output logic signed [TW-1:0]   w_re,
    output logic signed [TW-1:0]   w_im
);

    logic signed [TW-1:0] cos_t [N];
    logic signed [TW-1:0] sin_t [N];

    for (genvar i = 0; i < N; i++) begin : g_tab
        localparam int C = tw_cos(i, N, TW);
        localparam int S = tw_sin(i, N, TW);
        assign cos_t[i] = TW'(C);
        assign sin_t[i] = TW'(S);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_re <= '0;
            w_im <= '0;
        end else begin
            w_re <= cos_t[k];
            w_im <= inv ? sin_t[k] : -sin_t[k];
        end
    end

endmodule

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback DIF FFT stage, length N, 3-edge latency.
// Define SDF_SCALE_EN to halve butterfly outputs (cascade scales by 1/N).
module sdf_r2_stage
    import fft_pkg::*;
#(
    parameter int N  = 8,
    parameter int DW = 32,
    parameter int TW = 18
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic                 inv,
    input  logic signed [DW-1:0] in_real,
    input  logic signed [DW-1:0] in_img,
    output logic                 out_valid,
    output logic                 out_sop,
    output logic signed [DW-1:0] out_real,
    output logic signed [DW-1:0] out_img,
    output logic                 err_sync
);

    localparam int CW = $clog2(N);
    localparam int H  = N / 2;
    localparam int PW = DW + TW + 1;
    localparam int FB = TW - 2;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    logic [CW-1:0] cnt, cnt_eff, k_sel;
    logic          primed, inv_cur, inv_prev;
    logic          resync, wrap, emit, bin0;
    phase_e        ph;
    cplx_t         dly [H];
    cplx_t         x_in, head, bf_sum, bf_dif, bf_out;

    assign x_in    = {in_real, in_img};
    assign head    = dly[H-1];
    assign resync  = in_valid && in_sop && (cnt != '0);
    assign cnt_eff = resync ? '0 : cnt;
    assign ph      = cnt_eff[CW-1] ? PH_B : PH_A;
    assign wrap    = (cnt_eff == CW'(N - 1));
    assign emit    = in_valid && ((ph == PH_B) || (primed && !resync));
    assign bin0    = (ph == PH_B) && (cnt_eff == CW'(H));
    assign k_sel   = (ph == PH_B) ? '0 : cnt_eff;

`ifdef SDF_SCALE_EN
    logic signed [DW:0] sr, si, dr, di;
    assign sr = {head.re[DW-1], head.re} + {x_in.re[DW-1], x_in.re};
    assign si = {head.im[DW-1], head.im} + {x_in.im[DW-1], x_in.im};
    assign dr = {head.re[DW-1], head.re} - {x_in.re[DW-1], x_in.re};
    assign di = {head.im[DW-1], head.im} - {x_in.im[DW-1], x_in.im};
    assign bf_sum = {sr[DW:1], si[DW:1]};
    assign bf_dif = {dr[DW:1], di[DW:1]};
`else
    assign bf_sum = {head.re + x_in.re, head.im + x_in.im};
    assign bf_dif = {head.re - x_in.re, head.im - x_in.im};
`endif

    assign bf_out = (ph == PH_B) ? bf_sum : head;

    // Counter, framing state and delay line advance only on accepted samples
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            primed   <= 1'b0;
            inv_cur  <= 1'b0;
            inv_prev <= 1'b0;
            err_sync <= 1'b0;
            for (int i = 0; i < H; i++) dly[i] <= '0;
        end else if (in_valid) begin
            cnt <= cnt_eff + CW'(1);
            if (wrap) primed <= 1'b1;
            else if (resync) primed <= 1'b0;
            if (in_sop) inv_cur <= inv;
            if (wrap) inv_prev <= inv_cur;
            if (resync) err_sync <= 1'b1;
            dly[0] <= (ph == PH_B) ? bf_dif : x_in;
            for (int i = 1; i < H; i++) dly[i] <= dly[i-1];
        end
    end

    cplx_t                s1_d;
    logic                 s1_v, s1_sop;
    logic signed [TW-1:0] w_re, w_im;

    sdf_twiddle_rom #(.N(N), .TW(TW)) u_rom (
        .clk  (clk),
        .rstn (rstn),
        .k    (k_sel),
        .inv  (inv_prev),
        .w_re (w_re),
        .w_im (w_im)
    );

    logic signed [PW-1:0] m_re, m_im, p_re, p_im;
    logic                 s2_v, s2_sop;

    assign m_re = PW'(s1_d.re) * PW'(w_re) - PW'(s1_d.im) * PW'(w_im);
    assign m_im = PW'(s1_d.re) * PW'(w_im) + PW'(s1_d.im) * PW'(w_re);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_d      <= '0;
            s1_v      <= 1'b0;
            s1_sop    <= 1'b0;
            p_re      <= '0;
            p_im      <= '0;
            s2_v      <= 1'b0;
            s2_sop    <= 1'b0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_real  <= '0;
            out_img   <= '0;
        end else begin
            s1_d      <= bf_out;
            s1_v      <= emit;
            s1_sop    <= emit && bin0;
            p_re      <= m_re;
            p_im      <= m_im;
            s2_v      <= s1_v;
            s2_sop    <= s1_sop;
            out_valid <= s2_v;
            out_sop   <= s2_sop;
            if (s2_v) begin
                out_real <= DW'(p_re >>> FB);
                out_img  <= DW'(p_im >>> FB);
            end
        end
    end

endmodule
